rename_dep_stage: RTL and testbench

Parametrised rename dependency-resolution stage for a WIDTH-wide rename group. It combines RAT lookups with free-list allocations and resolves intra-group RAW and WAW dependencies using youngest-older-lane priority. It also resolves cross-group RAW/WAW against the group leaving the stage in the same cycle, whose RAT write has not yet landed. Results go into a one-entry valid/ready pipeline register that feeds dispatch.

---
 rtl/rename_dep_stage_if.sv | 39 +++
 rtl/rename_dep_stage.sv | 142 ++++++++++++++
 tb/tb_rename_dep_stage.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_dep_stage_if.sv
// rtl/rename_dep_stage_if.sv - rename group in/out bundle between rename and dispatch
interface rename_dep_stage_if #(
    parameter int WIDTH  = 4,
    parameter int AREG_W = 5,
    parameter int PREG_W = 7
);
    logic                      flush_i;
    logic                      s_vld_i;
    logic                      s_rdy_o;
    logic [WIDTH-1:0]          inst_vld_i;
    logic [WIDTH*AREG_W-1:0]   ars1_i;
    logic [WIDTH*AREG_W-1:0]   ars2_i;
    logic [WIDTH*AREG_W-1:0]   ard_i;
    logic [WIDTH-1:0]          ard_vld_i;
    logic [WIDTH*PREG_W-1:0]   rat_prs1_i;
    logic [WIDTH*PREG_W-1:0]   rat_prs2_i;
    logic [WIDTH*PREG_W-1:0]   rat_prd_old_i;
    logic [WIDTH*PREG_W-1:0]   fl_prd_i;
    logic                      m_vld_o;
    logic                      m_rdy_i;
    logic [WIDTH-1:0]          inst_vld_o;
    logic [WIDTH-1:0]          ard_vld_o;
    logic [WIDTH*PREG_W-1:0]   prs1_o;
    logic [WIDTH*PREG_W-1:0]   prs2_o;
    logic [WIDTH*PREG_W-1:0]   prd_o;
    logic [WIDTH*PREG_W-1:0]   prd_old_o;

    modport master (
        output flush_i, s_vld_i, inst_vld_i, ars1_i, ars2_i, ard_i, ard_vld_i,
               rat_prs1_i, rat_prs2_i, rat_prd_old_i, fl_prd_i, m_rdy_i,
        input  s_rdy_o, m_vld_o, inst_vld_o, ard_vld_o, prs1_o, prs2_o, prd_o, prd_old_o
    );

    modport slave (
        input  flush_i, s_vld_i, inst_vld_i, ars1_i, ars2_i, ard_i, ard_vld_i,
               rat_prs1_i, rat_prs2_i, rat_prd_old_i, fl_prd_i, m_rdy_i,
        output s_rdy_o, m_vld_o, inst_vld_o, ard_vld_o, prs1_o, prs2_o, prd_o, prd_old_o
    );
endinterface

// File: rtl/rename_dep_stage.sv
// rtl/rename_dep_stage.sv - intra/cross-group RAW/WAW resolution feeding a one-entry output register
module rename_dep_stage #(
    parameter int WIDTH     = 4,
    parameter int AREG_W    = 5,
    parameter int PREG_W    = 7,
    parameter int ZERO_AREG = 31
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rename_dep_stage_if.slave  bus
);
    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [PREG_W-1:0] preg_t;

    localparam areg_t ZERO = AREG_W'(ZERO_AREG);

    areg_t ars1 [WIDTH];
    areg_t ars2 [WIDTH];
    areg_t ard  [WIDTH];
    preg_t rat1 [WIDTH];
    preg_t rat2 [WIDTH];
    preg_t ratold [WIDTH];
    preg_t fl   [WIDTH];
    logic [WIDTH-1:0] wr;

    logic             m_vld_q;
    logic [WIDTH-1:0] inst_vld_q;
    logic [WIDTH-1:0] ard_vld_q;
    areg_t            ard_q     [WIDTH];
    preg_t            prs1_q    [WIDTH];
    preg_t            prs2_q    [WIDTH];
    preg_t            prd_q     [WIDTH];
    preg_t            prd_old_q [WIDTH];

    preg_t            prs1_d    [WIDTH];
    preg_t            prs2_d    [WIDTH];
    preg_t            prd_old_d [WIDTH];

    logic s_rdy;
    logic fire_out;
    logic xbyp_en;
    logic accept;

    assign s_rdy    = ~m_vld_q | bus.m_rdy_i;
    assign fire_out = m_vld_q & bus.m_rdy_i;
    // the leaving group's RAT write is only real if flush does not cancel it
    assign xbyp_en  = fire_out & ~bus.flush_i;
    assign accept   = bus.s_vld_i & s_rdy & ~bus.flush_i;

    assign bus.s_rdy_o    = s_rdy;
    assign bus.m_vld_o    = m_vld_q;
    assign bus.inst_vld_o = inst_vld_q;
    assign bus.ard_vld_o  = ard_vld_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        assign ars1[g]   = bus.ars1_i[g*AREG_W +: AREG_W];
        assign ars2[g]   = bus.ars2_i[g*AREG_W +: AREG_W];
        assign ard[g]    = bus.ard_i[g*AREG_W +: AREG_W];
        assign rat1[g]   = bus.rat_prs1_i[g*PREG_W +: PREG_W];
        assign rat2[g]   = bus.rat_prs2_i[g*PREG_W +: PREG_W];
        assign ratold[g] = bus.rat_prd_old_i[g*PREG_W +: PREG_W];
        assign fl[g]     = bus.fl_prd_i[g*PREG_W +: PREG_W];
        assign wr[g]     = bus.inst_vld_i[g] & bus.ard_vld_i[g] & (ard[g] != ZERO);

        assign bus.prs1_o[g*PREG_W +: PREG_W]    = prs1_q[g];
        assign bus.prs2_o[g*PREG_W +: PREG_W]    = prs2_q[g];
        assign bus.prd_o[g*PREG_W +: PREG_W]     = prd_q[g];
        assign bus.prd_old_o[g*PREG_W +: PREG_W] = prd_old_q[g];
    end

    // Per lane, three lookups (rs1, rs2, old dest) share one priority chain:
    // RAT < leaving group (highest lane wins) < older lane in this group (youngest wins).
    always_comb begin
        areg_t key;
        preg_t res;
        key = '0;
        res = '0;
        for (int k = 0; k < WIDTH; k++) begin
            prs1_d[k]    = '0;
            prs2_d[k]    = '0;
            prd_old_d[k] = '0;
        end
        for (int k = 0; k < WIDTH; k++) begin
            for (int s = 0; s < 3; s++) begin
                case (s)
                    0:       begin key = ars1[k]; res = rat1[k];   end
                    1:       begin key = ars2[k]; res = rat2[k];   end
                    default: begin key = ard[k];  res = ratold[k]; end
                endcase
                if (bus.inst_vld_i[k] && (key != ZERO)) begin
                    if (xbyp_en) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (ard_vld_q[i] && (ard_q[i] == key)) begin
                                res = prd_q[i];
                            end
                        end
                    end
                    for (int j = 0; j < WIDTH; j++) begin
                        if ((j < k) && wr[j] && (ard[j] == key)) begin
                            res = fl[j];
                        end
                    end
                end
                case (s)
                    0:       prs1_d[k]    = res;
                    1:       prs2_d[k]    = res;
                    default: prd_old_d[k] = res;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_vld_q    <= 1'b0;
            inst_vld_q <= '0;
            ard_vld_q  <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                ard_q[k]     <= '0;
                prs1_q[k]    <= '0;
                prs2_q[k]    <= '0;
                prd_q[k]     <= '0;
                prd_old_q[k] <= '0;
            end
        end else if (bus.flush_i) begin
            m_vld_q <= 1'b0;
        end else if (accept) begin
            m_vld_q    <= 1'b1;
            inst_vld_q <= bus.inst_vld_i;
            ard_vld_q  <= wr;
            for (int k = 0; k < WIDTH; k++) begin
                ard_q[k]     <= ard[k];
                prs1_q[k]    <= prs1_d[k];
                prs2_q[k]    <= prs2_d[k];
                prd_q[k]     <= fl[k];
                prd_old_q[k] <= prd_old_d[k];
            end
        end else if (fire_out) begin
            m_vld_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rename_dep_stage.sv
// tb/tb_rename_dep_stage.sv - randomized and directed bench for rename_dep_stage
module tb_rename_dep_stage;
    localparam int W  = 4;
    localparam int AW = 5;
    localparam int PW = 7;
    localparam int ZR = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rename_dep_stage_if #(.WIDTH(W), .AREG_W(AW), .PREG_W(PW)) bus();
    rename_dep_stage #(.WIDTH(W), .AREG_W(AW), .PREG_W(PW), .ZERO_AREG(ZR)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] i_vld, i_dvld;
    int i_rs1[W], i_rs2[W], i_rd[W], r_p1[W], r_p2[W], r_pold[W], f_prd[W];
    logic s_vld, m_rdy, flush;

    bit e_mvld;
    bit e_iv[W], e_dv[W];
    int e_rd[W], e_p1[W], e_p2[W], e_pd[W], e_po[W];

    function automatic int o_p1(int k); return int'(bus.prs1_o[k*PW +: PW]); endfunction
    function automatic int o_p2(int k); return int'(bus.prs2_o[k*PW +: PW]); endfunction
    function automatic int o_pd(int k); return int'(bus.prd_o[k*PW +: PW]); endfunction
    function automatic int o_po(int k); return int'(bus.prd_old_o[k*PW +: PW]); endfunction

    task automatic model_reset();
        e_mvld = 0;
        for (int k = 0; k < W; k++) begin
            e_iv[k] = 0; e_dv[k] = 0; e_rd[k] = 0;
            e_p1[k] = 0; e_p2[k] = 0; e_pd[k] = 0; e_po[k] = 0;
        end
    endtask

    task automatic clear_inputs();
        s_vld = 0; flush = 0; m_rdy = 1; i_vld = '0; i_dvld = '0;
        for (int k = 0; k < W; k++) begin
            i_rs1[k] = 20 + k; i_rs2[k] = 24 + k; i_rd[k] = 8 + k;
            r_p1[k] = 0; r_p2[k] = 0; r_pold[k] = 0; f_prd[k] = 0;
        end
    endtask

    task automatic drive();
        bus.s_vld_i    = s_vld;
        bus.flush_i    = flush;
        bus.m_rdy_i    = m_rdy;
        bus.inst_vld_i = i_vld;
        bus.ard_vld_i  = i_dvld;
        for (int k = 0; k < W; k++) begin
            bus.ars1_i[k*AW +: AW]        = AW'(i_rs1[k]);
            bus.ars2_i[k*AW +: AW]        = AW'(i_rs2[k]);
            bus.ard_i[k*AW +: AW]         = AW'(i_rd[k]);
            bus.rat_prs1_i[k*PW +: PW]    = PW'(r_p1[k]);
            bus.rat_prs2_i[k*PW +: PW]    = PW'(r_p2[k]);
            bus.rat_prd_old_i[k*PW +: PW] = PW'(r_pold[k]);
            bus.fl_prd_i[k*PW +: PW]      = PW'(f_prd[k]);
        end
    endtask

    // Newest mapping of arch register a as seen by lane k: nearest older writer
    // in this group, else the last writer of the group leaving now, else the RAT.
    function automatic int lookup(int k, int a, int rat, bit xen);
        if (!i_vld[k] || a == ZR) return rat;
        for (int j = k - 1; j >= 0; j--)
            if (i_vld[j] && i_dvld[j] && i_rd[j] != ZR && i_rd[j] == a) return f_prd[j];
        if (xen)
            for (int i = W - 1; i >= 0; i--)
                if (e_dv[i] && e_rd[i] == a) return e_pd[i];
        return rat;
    endfunction

    task automatic step();
        bit fire, xen, acc;
        int n1[W], n2[W], no[W];
        drive();
        fire = e_mvld && m_rdy;
        xen  = fire && !flush;
        acc  = s_vld && (!e_mvld || m_rdy) && !flush;
        for (int k = 0; k < W; k++) begin
            n1[k] = lookup(k, i_rs1[k], r_p1[k], xen);
            n2[k] = lookup(k, i_rs2[k], r_p2[k], xen);
            no[k] = lookup(k, i_rd[k], r_pold[k], xen);
        end
        @(posedge clk);
        #1;
        if (flush) e_mvld = 0;
        else if (acc) begin
            e_mvld = 1;
            for (int k = 0; k < W; k++) begin
                e_iv[k] = i_vld[k];
                e_dv[k] = i_vld[k] && i_dvld[k] && i_rd[k] != ZR;
                e_rd[k] = i_rd[k];
                e_p1[k] = n1[k]; e_p2[k] = n2[k]; e_po[k] = no[k]; e_pd[k] = f_prd[k];
            end
        end else if (fire) e_mvld = 0;
    endtask

    task automatic drain();
        s_vld = 0; m_rdy = 1; flush = 0;
        step();
        step();
    endtask

    function automatic int rnd_areg();
        if ($urandom_range(0, 7) == 0) return ZR;
        return int'($urandom_range(0, 5));
    endfunction

    task automatic rand_group();
        for (int k = 0; k < W; k++) begin
            i_vld[k]  = ($urandom_range(0, 7) != 0);
            i_dvld[k] = ($urandom_range(0, 3) != 0);
            i_rs1[k]  = rnd_areg(); i_rs2[k] = rnd_areg(); i_rd[k] = rnd_areg();
            r_p1[k]   = int'($urandom_range(0, 127));
            r_p2[k]   = int'($urandom_range(0, 127));
            r_pold[k] = int'($urandom_range(0, 127));
            f_prd[k]  = int'($urandom_range(0, 127));
        end
    endtask

    task automatic test_reset();
        n_chk++; if (bus.m_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_m_vld: got %0b expected 0", bus.m_vld_o); end
        n_chk++; if (bus.inst_vld_o !== '0) begin n_fail++; $display("FAIL reset_inst_vld: got %0h expected 0", bus.inst_vld_o); end
        n_chk++; if (bus.ard_vld_o !== '0) begin n_fail++; $display("FAIL reset_ard_vld: got %0h expected 0", bus.ard_vld_o); end
        n_chk++; if ((bus.prs1_o | bus.prs2_o | bus.prd_o | bus.prd_old_o) !== '0) begin n_fail++; $display("FAIL reset_preg: got nonzero expected 0"); end
        n_chk++; if (bus.s_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_s_rdy: got %0b expected 1", bus.s_rdy_o); end
    endtask

    task automatic test_no_dep();
        clear_inputs();
        s_vld = 1; i_vld = '1; i_dvld = '1;
        for (int k = 0; k < W; k++) begin
            i_rs1[k] = k; i_rs2[k] = 4 + k; i_rd[k] = 8 + k;
            r_p1[k] = 10 + k; r_p2[k] = 30 + k; f_prd[k] = 60 + k;
        end
        step();
        n_chk++; if (bus.m_vld_o !== 1'b1) begin n_fail++; $display("FAIL nodep_m_vld: got %0b expected 1", bus.m_vld_o); end
        for (int k = 0; k < W; k++) begin
            n_chk++; if (o_p1(k) !== 10 + k) begin n_fail++; $display("FAIL nodep_prs1 lane%0d: got %0d expected %0d", k, o_p1(k), 10 + k); end
            n_chk++; if (o_pd(k) !== 60 + k) begin n_fail++; $display("FAIL nodep_prd lane%0d: got %0d expected %0d", k, o_pd(k), 60 + k); end
        end
        drain();
    endtask

    task automatic test_intra_chain();
        clear_inputs();
        s_vld = 1; i_vld = 4'b1101; i_dvld = 4'b0011;
        i_rd[0] = 3; f_prd[0] = 40;
        i_rd[1] = 3; f_prd[1] = 41;
        i_rs1[2] = 3; r_p1[2] = 20;
        i_rs2[3] = 3; r_p2[3] = 21;
        step();
        n_chk++; if (o_p1(2) !== 40) begin n_fail++; $display("FAIL chain_l2_prs1: got %0d expected 40", o_p1(2)); end
        n_chk++; if (o_p2(3) !== 40) begin n_fail++; $display("FAIL chain_l3_prs2: got %0d expected 40", o_p2(3)); end
        n_chk++; if (bus.inst_vld_o[1] !== 1'b0) begin n_fail++; $display("FAIL chain_l1_inst_vld: got %0b expected 0", bus.inst_vld_o[1]); end
        drain();
        s_vld = 1; i_vld = 4'b1111; r_pold[1] = 22;
        step();
        n_chk++; if (o_p1(2) !== 41) begin n_fail++; $display("FAIL chain2_l2_prs1: got %0d expected 41", o_p1(2)); end
        n_chk++; if (o_po(1) !== 40) begin n_fail++; $display("FAIL chain2_l1_prd_old: got %0d expected 40", o_po(1)); end
        drain();
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        s_vld = 1; i_vld = '1; i_dvld = 4'b0001;
        i_rd[0] = ZR; f_prd[0] = 45;
        i_rs1[1] = ZR; r_p1[1] = 5;
        step();
        n_chk++; if (o_p1(1) !== 5) begin n_fail++; $display("FAIL zero_l1_prs1: got %0d expected 5", o_p1(1)); end
        n_chk++; if (bus.ard_vld_o[0] !== 1'b0) begin n_fail++; $display("FAIL zero_ard_vld0: got %0b expected 0", bus.ard_vld_o[0]); end
        drain();
    endtask

    task automatic test_cross_group();
        clear_inputs();
        s_vld = 1; i_vld = '1; i_dvld = 4'b1000;
        i_rd[3] = 7; f_prd[3] = 50;
        step();
        clear_inputs();
        s_vld = 1; i_vld = '1; i_dvld = 4'b0011;
        i_rd[0] = 13; i_rs2[0] = 7; r_p2[0] = 12;
        i_rd[1] = 7; r_pold[1] = 12;
        step();
        n_chk++; if (o_p2(0) !== 50) begin n_fail++; $display("FAIL cross_l0_prs2: got %0d expected 50", o_p2(0)); end
        n_chk++; if (o_po(1) !== 50) begin n_fail++; $display("FAIL cross_l1_prd_old: got %0d expected 50", o_po(1)); end
    endtask

    task automatic test_backpressure();
        m_rdy = 0; s_vld = 1; flush = 0;
        for (int c = 0; c < 3; c++) begin
            rand_group();
            drive();
            #1;
            n_chk++; if (bus.s_rdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_s_rdy cyc%0d: got %0b expected 0", c, bus.s_rdy_o); end
            step();
            n_chk++; if (bus.m_vld_o !== 1'b1) begin n_fail++; $display("FAIL bp_m_vld cyc%0d: got %0b expected 1", c, bus.m_vld_o); end
            for (int k = 0; k < W; k++) begin
                n_chk++;
                if (o_p1(k) !== e_p1[k] || o_p2(k) !== e_p2[k] || o_pd(k) !== e_pd[k] || o_po(k) !== e_po[k]) begin
                    n_fail++;
                    $display("FAIL bp_hold lane%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", k,
                             o_p1(k), o_p2(k), o_pd(k), o_po(k), e_p1[k], e_p2[k], e_pd[k], e_po[k]);
                end
            end
        end
        m_rdy = 1;
        rand_group();
        i_rs1[0] = e_rd[W-1];
        step();
        n_chk++; if (bus.m_vld_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_m_vld: got %0b expected 1", bus.m_vld_o); end
        for (int k = 0; k < W; k++) begin
            n_chk++;
            if (o_p1(k) !== e_p1[k] || o_p2(k) !== e_p2[k] || o_pd(k) !== e_pd[k] || o_po(k) !== e_po[k]) begin
                n_fail++;
                $display("FAIL bp_release lane%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", k,
                         o_p1(k), o_p2(k), o_pd(k), o_po(k), e_p1[k], e_p2[k], e_pd[k], e_po[k]);
            end
        end
    endtask

    task automatic test_flush();
        s_vld = 1; m_rdy = 1; flush = 1;
        rand_group();
        step();
        n_chk++; if (bus.m_vld_o !== 1'b0) begin n_fail++; $display("FAIL flush_m_vld: got %0b expected 0", bus.m_vld_o); end
        flush = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rand_group();
            s_vld = ($urandom_range(0, 3) != 0);
            m_rdy = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            drive();
            #1;
            n_chk++; if (bus.s_rdy_o !== (!e_mvld || m_rdy)) begin n_fail++; $display("FAIL rnd_s_rdy cyc%0d: got %0b expected %0b", c, bus.s_rdy_o, (!e_mvld || m_rdy)); end
            step();
            n_chk++; if (bus.m_vld_o !== e_mvld) begin n_fail++; $display("FAIL rnd_m_vld cyc%0d: got %0b expected %0b", c, bus.m_vld_o, e_mvld); end
            for (int k = 0; k < W; k++) begin
                n_chk++;
                if (bus.inst_vld_o[k] !== e_iv[k] || bus.ard_vld_o[k] !== e_dv[k] ||
                    o_p1(k) !== e_p1[k] || o_p2(k) !== e_p2[k] || o_pd(k) !== e_pd[k] || o_po(k) !== e_po[k]) begin
                    n_fail++;
                    $display("FAIL rnd_lane cyc%0d lane%0d: got v%0b d%0b %0d/%0d/%0d/%0d expected v%0b d%0b %0d/%0d/%0d/%0d",
                             c, k, bus.inst_vld_o[k], bus.ard_vld_o[k], o_p1(k), o_p2(k), o_pd(k), o_po(k),
                             e_iv[k], e_dv[k], e_p1[k], e_p2[k], e_pd[k], e_po[k]);
                end
            end
        end
        flush = 0;
    endtask

    task automatic test_async_reset();
        clear_inputs();
        s_vld = 1; m_rdy = 0;
        rand_group();
        i_vld = '1;
        step();
        n_chk++; if (bus.m_vld_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre_m_vld: got %0b expected 1", bus.m_vld_o); end
        #2 rst = 1;
        #1;
        n_chk++; if (bus.m_vld_o !== 1'b0) begin n_fail++; $display("FAIL arst_m_vld: got %0b expected 0", bus.m_vld_o); end
        n_chk++; if ((bus.inst_vld_o | bus.ard_vld_o) !== '0) begin n_fail++; $display("FAIL arst_vld: got %0h expected 0", bus.inst_vld_o | bus.ard_vld_o); end
        n_chk++; if ((bus.prs1_o | bus.prs2_o | bus.prd_o | bus.prd_old_o) !== '0) begin n_fail++; $display("FAIL arst_preg: got nonzero expected 0"); end
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_no_dep();
        test_intra_chain();
        test_zero_reg();
        test_cross_group();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
